// File: rtl/rv_writeback.sv
// rv_writeback: uRV writeback stage. Extracts and extends load data, stalls while a load is outstanding,
// and issues one registered register-file write per instruction. Define RV_WB_MISALIGN_CHECK_EN for misaligned-load trapping.
module rv_writeback #(
    parameter int LOAD_TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic        w_stall_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_write_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_load_err_o,
    output logic        w_misaligned_o
);
    typedef enum logic {ST_IDLE, ST_WAIT_LOAD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_rd;
    logic [2:0]  r_fun;
    logic [1:0]  r_addr;
    logic [15:0] r_cnt;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_value;
    logic        r_rf_write;
    logic        r_load_err;
    logic        r_misaligned;

    logic        w_accept;
    logic        w_load_done;
    logic        w_expire;
    logic        w_timeout;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_value;

`ifdef RV_WB_MISALIGN_CHECK_EN
    always_comb begin
        case (x_fun_i)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = x_dm_addr_i[0];
            default:        w_misaligned = (x_dm_addr_i != 2'b00);
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    generate
        if (LOAD_TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_cnt == 16'(LOAD_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Extraction uses the address/funct3 captured at acceptance, not the live execute inputs.
    always_comb begin
        case (r_addr)
            2'd0:    w_byte = dm_data_l_i[7:0];
            2'd1:    w_byte = dm_data_l_i[15:8];
            2'd2:    w_byte = dm_data_l_i[23:16];
            default: w_byte = dm_data_l_i[31:24];
        endcase
        w_half = r_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
        case (r_fun)
            3'b000:  w_load_value = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_value = {24'd0, w_byte};
            3'b001:  w_load_value = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_value = {16'd0, w_half};
            default: w_load_value = dm_data_l_i;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_done  = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (x_valid_i) begin
                    w_accept = 1'b1;
                    if (x_load_i && !w_misaligned) begin
                        w_state_next = ST_WAIT_LOAD;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                // A done arriving on the expiry cycle takes priority over the timeout.
                if (dm_load_done_i) begin
                    w_load_done  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_expire     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd         <= '0;
            r_fun        <= '0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_rf_rd      <= '0;
            r_rf_value   <= '0;
            r_rf_write   <= 1'b0;
            r_load_err   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_rf_write   <= 1'b0;
            r_load_err   <= w_expire;
            r_misaligned <= w_accept && x_load_i && w_misaligned;
            if (w_accept && !x_load_i && x_rd_write_i && (x_rd_i != 5'd0)) begin
                r_rf_write <= 1'b1;
                r_rf_rd    <= x_rd_i;
                r_rf_value <= x_rd_value_i;
            end
            if (w_accept && x_load_i) begin
                r_rd   <= x_rd_i;
                r_fun  <= x_fun_i;
                r_addr <= x_dm_addr_i;
                r_cnt  <= '0;
            end
            if (w_load_done && (r_rd != 5'd0)) begin
                r_rf_write <= 1'b1;
                r_rf_rd    <= r_rd;
                r_rf_value <= w_load_value;
            end
            if ((r_state == ST_WAIT_LOAD) && !dm_load_done_i && !w_timeout) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign w_stall_o           = (r_state == ST_WAIT_LOAD);
    assign rf_rd_o             = r_rf_rd;
    assign rf_rd_value_o       = r_rf_value;
    assign rf_rd_write_o       = r_rf_write;
    assign w_bypass_rd_write_o = r_rf_write;
    assign w_bypass_rd_value_o = r_rf_value;
    assign w_load_err_o        = r_load_err;
    assign w_misaligned_o      = r_misaligned;
endmodule

// File: doc/rv_writeback.md
Name: rv_writeback

Overview:
- Writeback stage of the uRV pipeline; sits directly upstream of the register file write port and its W-stage bypass inputs.
- Takes completed execute-stage results and load responses from the data memory.
- Aligns and sign/zero-extends load data, stalls the pipeline while a load is outstanding, then drives one registered register-file write per instruction.

Parameters:
- LOAD_TIMEOUT, 0: cycles waited for dm_load_done_i before abandoning a load; 0 = wait forever; max 65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- x_valid_i  in  1  execute stage presents an instruction
- x_rd_i  in  5  destination register
- x_rd_value_i  in  32  ALU result for non-loads
- x_rd_write_i  in  1  instruction writes rd
- x_load_i  in  1  instruction is a load
- x_fun_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- x_dm_addr_i  in  2  low bits of load address
- dm_data_l_i  in  32  load data from memory
- dm_load_done_i  in  1  load data valid this cycle
- w_stall_o  out  1  stage busy; upstream must hold
- rf_rd_o  out  5  register file write address
- rf_rd_value_o  out  32  register file write data
- rf_rd_write_o  out  1  register file write strobe
- w_bypass_rd_write_o  out  1  bypass valid to register file
- w_bypass_rd_value_o  out  32  bypass data
- w_load_err_o  out  1  one-cycle pulse on load timeout
- w_misaligned_o  out  1  one-cycle pulse on misaligned load (feature only)

Behaviour:
- Reset:
  - State IDLE, timeout counter 0.
  - All outputs 0.
  - Reset asserted mid-load abandons the load: no write, no error pulse.
- Acceptance: an instruction is accepted at a clock edge where x_valid_i=1 and w_stall_o=0.
- States:
  - IDLE:
    - Accepted non-load: rf_rd_o/rf_rd_value_o registered; rf_rd_write_o=x_rd_write_i && x_rd_i!=0 for exactly the next cycle.
    - Accepted load: capture rd, fun, addr; go to WAIT_LOAD.
    - No accept: rf_rd_write_o=0.
  - WAIT_LOAD:
    - w_stall_o=1 (decoded from state register).
    - dm_load_done_i is sampled only in this state, so the earliest completion is the edge after acceptance.
    - On a sampled done: register the extended data and rf_rd_write_o=(rd!=0) for one cycle; return to IDLE.
    - An instruction presented in that same cycle is not accepted, because stall is still 1.
- Load extraction:
  - LB/LBU: byte dm_data_l_i[8*addr+7 : 8*addr], sign-extended for LB, zero-extended for LBU.
  - LH/LHU: halfword at addr[1] (bits 15:0 or 31:16), sign-extended for LH, zero-extended for LHU.
  - LW: full word.
  - Other funct3 codes are treated as LW.
- Timeout (LOAD_TIMEOUT>0):
  - Counter clears on entry to WAIT_LOAD and increments each cycle without done.
  - When count reaches LOAD_TIMEOUT-1 without done: next cycle is IDLE, no write, w_load_err_o pulses 1 cycle.
  - Done in the same cycle as expiry wins: normal write, no error.
- Bypass: w_bypass_rd_write_o and w_bypass_rd_value_o are identical to rf_rd_write_o and rf_rd_value_o in every cycle.
- rf_rd_o and rf_rd_value_o hold their last value when no write is strobed.
- Back-to-back non-loads write on consecutive cycles, with no bubbles.

Optional Feature:
- Macro: RV_WB_MISALIGN_CHECK_EN.
- Defined:
  - A misaligned load is LH/LHU with addr[0]=1, or LW with addr!=0.
  - Detected at acceptance: no WAIT_LOAD entry, no write, w_misaligned_o pulses the next cycle.
- Undefined:
  - w_misaligned_o is tied 0.
  - Extraction follows the rules above; low address bits that do not apply to the access size are ignored.

Test Plan:
- ALU op rd=5, value 0x1234_5678, accepted at edge N -> rf_rd_write_o=1, rf_rd_o=5, value 0x1234_5678 during cycle N+1 only; bypass outputs equal.
- LB, addr=2, done 3 cycles after accept, data 0x0080_0000 -> w_stall_o=1 for 3 cycles; write value 0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- LHU, addr=2, data 0xBEEF_1234 -> 0x0000_BEEF. LH, same data -> 0xFFFF_BEEF.
- Writes to rd=0, ALU and load -> rf_rd_write_o stays 0; load still stalls until done.
- LOAD_TIMEOUT=4, no done -> stall 4 cycles, w_load_err_o pulses once, no write, next instruction accepted. Reset asserted in WAIT_LOAD -> outputs 0 immediately, no later write.
- With RV_WB_MISALIGN_CHECK_EN: LW addr=1 -> no stall, no write, w_misaligned_o 1-cycle pulse. Without the macro: same stimulus, data 0xCAFEBABE -> write 0xCAFEBABE.
